audio_tone_arbiter: RTL

- Tone scheduler and arbiter for the shared codec DAC path of the Simon game.
- Five requesters share one audio output: four colour-button tones and one error buzz.
- The block grants one requester at a time and synthesises a square wave for a fixed duration, followed by a silent gap.
- It drives 16-bit left/right sample words into the serialiser, paced by a one-cycle sample tick that runs at the DACLRCK rate in the iCLK domain.

---
 rtl/audio_tone_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/audio_tone_arbiter.sv
// Tone scheduler/arbiter for the shared codec DAC path: grants one of five
// requesters, plays a fixed-length square wave, then holds a silent gap.
module audio_tone_arbiter #(
    parameter int unsigned HALF0       = 58,
    parameter int unsigned HALF1       = 77,
    parameter int unsigned HALF2       = 95,
    parameter int unsigned HALF3       = 115,
    parameter int unsigned HALF4       = 571,
    parameter int unsigned DUR_SAMPLES = 24000,
    parameter int unsigned GAP_SAMPLES = 2400,
    parameter logic [15:0] AMP         = 16'h2000
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iSAMPLE_TICK,
    input  logic [4:0]  iREQ,
    input  logic        iCLR,
    output logic [15:0] oAUD_outL,
    output logic [15:0] oAUD_outR,
    output logic        oBUSY,
    output logic [2:0]  oACTIVE_CH,
    output logic        oDONE
);

    localparam int unsigned CW = 15;
    localparam int unsigned HW = 10;
    localparam logic [2:0]  NO_CH = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_e;

    state_e          state_q, state_d;
    logic [4:0]      pend_q, pend_d;
    logic [2:0]      ch_q, ch_d;
    logic [HW-1:0]   half_q, half_d;
    logic [CW-1:0]   dur_q, dur_d;
    logic [15:0]     samp_q, samp_d;
    logic            busy_q, busy_d;
    logic [2:0]      act_q, act_d;
    logic            done_q, done_d;

    logic [4:0]      cand_c;
    logic [2:0]      win_c;
    logic [HW-1:0]   half_last_c;
    logic            preempt_c;

    // Highest-index requester wins
    always_comb begin
        cand_c = pend_q | iREQ;
        win_c  = 3'd0;
        for (int i = 0; i < 5; i++) begin
            if (cand_c[i]) win_c = 3'(i);
        end
    end

    always_comb begin
        case (ch_q)
            3'd0:    half_last_c = HW'(HALF0 - 1);
            3'd1:    half_last_c = HW'(HALF1 - 1);
            3'd2:    half_last_c = HW'(HALF2 - 1);
            3'd3:    half_last_c = HW'(HALF3 - 1);
            default: half_last_c = HW'(HALF4 - 1);
        endcase
    end

    assign preempt_c = iREQ[4] &&
                       (((state_q == S_PLAY) && (ch_q != 3'd4)) || (state_q == S_GAP));

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q | iREQ;
        ch_d    = ch_q;
        half_d  = half_q;
        dur_d   = dur_q;
        samp_d  = samp_q;
        busy_d  = busy_q;
        act_d   = act_q;
        done_d  = 1'b0;
        if (iCLR) begin
            state_d = S_IDLE;
            pend_d  = '0;
            half_d  = '0;
            dur_d   = '0;
            samp_d  = '0;
            busy_d  = 1'b0;
            act_d   = NO_CH;
        end else if (preempt_c) begin
            // The abandoned tone is dropped, not re-queued
            state_d   = S_PLAY;
            pend_d[4] = 1'b0;
            ch_d      = 3'd4;
            half_d    = '0;
            dur_d     = '0;
            samp_d    = AMP;
            busy_d    = 1'b1;
            act_d     = 3'd4;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (|cand_c) begin
                        state_d = S_PLAY;
                        pend_d  = cand_c & ~(5'(1) << win_c);
                        ch_d    = win_c;
                        half_d  = '0;
                        dur_d   = '0;
                        samp_d  = AMP;
                        busy_d  = 1'b1;
                        act_d   = win_c;
                    end
                end
                S_PLAY: begin
                    if (iSAMPLE_TICK) begin
                        if (dur_q == CW'(DUR_SAMPLES - 1)) begin
                            state_d = S_GAP;
                            dur_d   = '0;
                            half_d  = '0;
                            samp_d  = '0;
                            done_d  = 1'b1;
                            act_d   = NO_CH;
                        end else begin
                            dur_d = dur_q + CW'(1);
                            if (half_q == half_last_c) begin
                                half_d = '0;
                                samp_d = -samp_q;
                            end else begin
                                half_d = half_q + HW'(1);
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (iSAMPLE_TICK) begin
                        if (dur_q == CW'(GAP_SAMPLES - 1)) begin
                            state_d = S_IDLE;
                            dur_d   = '0;
                            busy_d  = 1'b0;
                        end else begin
                            dur_d = dur_q + CW'(1);
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    act_d   = NO_CH;
                    samp_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state_q <= S_IDLE;
            pend_q  <= '0;
            ch_q    <= '0;
            half_q  <= '0;
            dur_q   <= '0;
            samp_q  <= '0;
            busy_q  <= 1'b0;
            act_q   <= NO_CH;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ch_q    <= ch_d;
            half_q  <= half_d;
            dur_q   <= dur_d;
            samp_q  <= samp_d;
            busy_q  <= busy_d;
            act_q   <= act_d;
            done_q  <= done_d;
        end
    end

    assign oAUD_outL  = samp_q;
    assign oAUD_outR  = samp_q;
    assign oBUSY      = busy_q;
    assign oACTIVE_CH = act_q;
    assign oDONE      = done_q;

endmodule
